// File: rtl/cmd_reg_slave.sv
// -----------------------------------------------------------------------------
// cmd_reg_slave
//   Responder end of the cmd bus. A master raises sel with rd_wr_n, byte_addr
//   and wdata and holds sel until ack. The block runs a small IDLE/WAIT/ACK
//   FSM with a programmable number of wait states. It then completes the access
//   against a bank of NUM_REGS word registers:
//     - RW registers drive ctrl_regs toward the fabric.
//     - RO registers (RO_MASK bit set) return the matching status_in slice.
//   Addresses that fail decode are still acked, so a bad access never stalls
//   the bus. Such accesses return ERR_DATA on reads and bump a saturating
//   error counter.
//
// Ports
//   clk        in   1                   system clock
//   rst_n      in   1                   async active-low reset (sync release)
//   sel        in   1                   cmd request, held until ack
//   rd_wr_n    in   1                   1 = read, 0 = write
//   byte_addr  in   ADDR_BITS           byte address
//   wdata      in   DATA_BITS           write data
//   ack        out  1                   one-cycle completion pulse
//   rdata      out  DATA_BITS           read data, valid with ack, held after
//   ctrl_regs  out  NUM_REGS*DATA_BITS  RW register contents, reg i at slice i
//   status_in  in   NUM_REGS*DATA_BITS  RO register sources
//   wr_pulse   out  NUM_REGS            one-cycle pulse per written register
//   err_cnt    out  8                   saturating decode-error count
// -----------------------------------------------------------------------------
module cmd_reg_slave #(
  parameter int unsigned          ADDR_BITS   = 26,
  parameter int unsigned          DATA_BITS   = 32,
  parameter int unsigned          NUM_REGS    = 16,
  parameter logic [ADDR_BITS-1:0] BASE_ADDR   = '0,
  parameter int unsigned          WAIT_STATES = 1,
  parameter logic [NUM_REGS-1:0]  RO_MASK     = '0,
  parameter logic [DATA_BITS-1:0] ERR_DATA    = DATA_BITS'(32'hBAD0_ADD0)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sel,
  input  logic                          rd_wr_n,
  input  logic [ADDR_BITS-1:0]          byte_addr,
  input  logic [DATA_BITS-1:0]          wdata,
  output logic                          ack,
  output logic [DATA_BITS-1:0]          rdata,
  output logic [NUM_REGS*DATA_BITS-1:0] ctrl_regs,
  input  logic [NUM_REGS*DATA_BITS-1:0] status_in,
  output logic [NUM_REGS-1:0]           wr_pulse,
  output logic [7:0]                    err_cnt
);

  localparam int unsigned          IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [3:0]           WS         = 4'(WAIT_STATES);
  localparam logic [ADDR_BITS-3:0] WORD_LIMIT = (ADDR_BITS-2)'(NUM_REGS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } state_t;

  // ---------------------------------------------------------------------------
  // Reset synchronizer: assertion reaches every flop at once, release is
  // aligned to clk so no flop sees a reset-recovery violation.
  // ---------------------------------------------------------------------------
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  // ---------------------------------------------------------------------------
  // State and captured request
  // ---------------------------------------------------------------------------
  state_t                 r_state, w_next_state;
  logic [3:0]             r_cnt, w_cnt_next;
  logic                   w_capture;
  logic                   w_fire;

  logic                   r_rd;
  logic [ADDR_BITS-1:0]   r_addr;
  logic [DATA_BITS-1:0]   r_wdata;

  logic                   r_ack;
  logic [DATA_BITS-1:0]   r_rdata;
  logic [NUM_REGS-1:0]    r_wr_pulse;
  logic [7:0]             r_err_cnt;
  logic [DATA_BITS-1:0]   r_regs [NUM_REGS];

  // NOTE: every output of an always_comb gets a default before the case so no
  // path leaves it unassigned -- that is what keeps latches from being inferred.
  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (sel) begin
          w_capture    = 1'b1;
          w_cnt_next   = WS;
          w_next_state = (WS == 4'd0) ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        // The WAIT cycle holding cnt==1 is the last one; sel dropping in any
        // WAIT cycle abandons the access with no side effects.
        if (!sel) begin
          w_next_state = ST_IDLE;
        end else if (r_cnt <= 4'd1) begin
          w_next_state = ST_ACK;
          w_cnt_next   = 4'd0;
        end else begin
          w_cnt_next   = r_cnt - 4'd1;
        end
      end
      ST_ACK:  w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // The access completes on the edge that enters ACK.
  assign w_fire = (w_next_state == ST_ACK);

  // ---------------------------------------------------------------------------
  // Decode. With zero wait states the access completes on the capture edge, so
  // the live inputs stand in for the not-yet-captured fields.
  // ---------------------------------------------------------------------------
  logic                 w_cur_rd;
  logic [ADDR_BITS-1:0] w_cur_addr;
  logic [DATA_BITS-1:0] w_cur_wdata;
  logic [ADDR_BITS-1:0] w_off;
  logic [ADDR_BITS-3:0] w_word;
  logic [IDX_W-1:0]     w_idx;
  logic                 w_err;
  logic                 w_is_ro;
  logic [DATA_BITS-1:0] w_rd_val;

  always_comb begin
    w_cur_rd    = (r_state == ST_IDLE) ? rd_wr_n   : r_rd;
    w_cur_addr  = (r_state == ST_IDLE) ? byte_addr : r_addr;
    w_cur_wdata = (r_state == ST_IDLE) ? wdata     : r_wdata;

    // Modular subtraction: addresses below BASE_ADDR wrap to a huge word
    // index and fall out through the range check.
    w_off   = w_cur_addr - BASE_ADDR;
    w_word  = w_off[ADDR_BITS-1:2];
    w_idx   = w_word[IDX_W-1:0];
    w_err   = (w_off[1:0] != 2'b00) || (w_word >= WORD_LIMIT);
    w_is_ro = RO_MASK[w_idx];

    if (w_err)        w_rd_val = ERR_DATA;
    else if (w_is_ro) w_rd_val = status_in[w_idx*DATA_BITS +: DATA_BITS];
    else              w_rd_val = r_regs[w_idx];
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_rd       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_ack      <= 1'b0;
      r_rdata    <= '0;
      r_wr_pulse <= '0;
      r_err_cnt  <= 8'd0;
      // NOTE: the register bank is reset explicitly because ctrl_regs is
      // visible to the fabric straight out of reset; a RAM-style bank left
      // unreset would hand it garbage.
      for (int i = 0; i < int'(NUM_REGS); i++) r_regs[i] <= '0;
    end else begin
      r_state    <= w_next_state;
      r_cnt      <= w_cnt_next;
      r_ack      <= w_fire;
      r_wr_pulse <= '0;

      if (w_capture) begin
        r_rd    <= rd_wr_n;
        r_addr  <= byte_addr;
        r_wdata <= wdata;
      end

      if (w_fire) begin
        if (w_err && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
        if (w_cur_rd) begin
          r_rdata <= w_rd_val;
        end else if (!w_err && !w_is_ro) begin
          r_regs[w_idx]     <= w_cur_wdata;
          r_wr_pulse[w_idx] <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ack      = r_ack;
  assign rdata    = r_rdata;
  assign wr_pulse = r_wr_pulse;
  assign err_cnt  = r_err_cnt;

  for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_ctrl
    assign ctrl_regs[g*DATA_BITS +: DATA_BITS] = r_regs[g];
  end

endmodule

// File: tb/tb_cmd_reg_slave.sv
// -----------------------------------------------------------------------------
// tb_cmd_reg_slave
//   Three instances of cmd_reg_slave with different configurations:
//     k=0 : WAIT_STATES=1, BASE_ADDR=0x100, reg 3 read-only
//     k=1 : WAIT_STATES=3, BASE_ADDR=0
//     k=2 : WAIT_STATES=0, BASE_ADDR=0
//   Directed steps in a single initial block. Each access pushes its expected
//   response onto a scoreboard queue; the entry is popped and compared when
//   ack appears.
// -----------------------------------------------------------------------------
module tb_cmd_reg_slave;

  localparam int AB = 26;
  localparam int DB = 32;
  localparam int NR = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             sel     [3];
  logic             rd_wr_n [3];
  logic [AB-1:0]    addr    [3];
  logic [DB-1:0]    wdata   [3];
  logic             ack     [3];
  logic [DB-1:0]    rdata   [3];
  logic [NR*DB-1:0] ctrl    [3];
  logic [NR*DB-1:0] status  [3];
  logic [NR-1:0]    pulse   [3];
  logic [7:0]       errc    [3];

  int ws [3] = '{1, 3, 0};

  cmd_reg_slave #(.WAIT_STATES(1), .BASE_ADDR(26'h100), .RO_MASK(16'h0008)) u_w1 (
    .clk(clk), .rst_n(rst_n), .sel(sel[0]), .rd_wr_n(rd_wr_n[0]),
    .byte_addr(addr[0]), .wdata(wdata[0]), .ack(ack[0]), .rdata(rdata[0]),
    .ctrl_regs(ctrl[0]), .status_in(status[0]), .wr_pulse(pulse[0]), .err_cnt(errc[0]));

  cmd_reg_slave #(.WAIT_STATES(3)) u_w3 (
    .clk(clk), .rst_n(rst_n), .sel(sel[1]), .rd_wr_n(rd_wr_n[1]),
    .byte_addr(addr[1]), .wdata(wdata[1]), .ack(ack[1]), .rdata(rdata[1]),
    .ctrl_regs(ctrl[1]), .status_in(status[1]), .wr_pulse(pulse[1]), .err_cnt(errc[1]));

  cmd_reg_slave #(.WAIT_STATES(0)) u_w0 (
    .clk(clk), .rst_n(rst_n), .sel(sel[2]), .rd_wr_n(rd_wr_n[2]),
    .byte_addr(addr[2]), .wdata(wdata[2]), .ack(ack[2]), .rdata(rdata[2]),
    .ctrl_regs(ctrl[2]), .status_in(status[2]), .wr_pulse(pulse[2]), .err_cnt(errc[2]));

  typedef struct {
    logic          chk_rd;
    logic [DB-1:0] rd;
    logic [NR-1:0] pl;
  } exp_t;

  exp_t sb [$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access on instance k. If sel is already high (back-to-back) the new
  // fields are driven at once and ack is due W+1 negedges later; otherwise sel
  // rises just after a posedge and ack is due W+2 negedges later. Once the
  // fields are captured the inputs are scrambled. The negedge after ack must
  // show ack low again.
  task automatic xact(input int k, input logic rd, input logic [AB-1:0] a,
                      input logic [DB-1:0] wd, input logic [DB-1:0] exp_rd,
                      input logic [NR-1:0] exp_pl, input bit hold, input string tag);
    exp_t e;
    int   lat, exp_lat, lat0;
    bit   hold_in;
    hold_in = sel[k];
    if (!hold_in) begin
      @(posedge clk); #1;
    end
    exp_lat = hold_in ? ws[k] + 1 : ws[k] + 2;
    lat0    = hold_in ? 1 : 2;
    sel[k] = 1'b1; rd_wr_n[k] = rd; addr[k] = a; wdata[k] = wd;
    sb.push_back(exp_t'{rd, exp_rd, exp_pl});
    lat = 0;
    while (lat < 32) begin
      @(negedge clk); lat++;
      if (ack[k]) break;
      if (lat >= lat0) begin
        rd_wr_n[k] = ~rd; addr[k] = ~a; wdata[k] = ~wd;
      end
    end
    e = sb.pop_front();
    check({tag, " latency"}, lat, exp_lat);
    if (ack[k]) begin
      if (e.chk_rd) check({tag, " rdata"}, rdata[k], e.rd);
      check({tag, " wr_pulse"}, 32'(pulse[k]), 32'(e.pl));
    end
    if (!hold) sel[k] = 1'b0;
    @(negedge clk);
    check({tag, " ack one cycle"}, 32'(ack[k]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_ack;
    bit seen_pl;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sel[k] = 1'b0; rd_wr_n[k] = 1'b0; addr[k] = '0; wdata[k] = '0; status[k] = '0;
    end
    status[0][3*DB +: DB] = 32'h0000_CAFE;

    // Reset state
    #12;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset ack k%0d", k),   32'(ack[k]),   32'd0);
      check($sformatf("reset rdata k%0d", k), rdata[k],      32'd0);
      check($sformatf("reset ctrl k%0d", k),  32'(|ctrl[k]), 32'd0);
      check($sformatf("reset pulse k%0d", k), 32'(pulse[k]), 32'd0);
      check($sformatf("reset errc k%0d", k),  32'(errc[k]),  32'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 1: write at W=1
    xact(0, 1'b0, 26'h108, 32'h1234_5678, '0, 16'h0004, 1'b0, "t1 write r2");
    check("t1 ctrl r2", ctrl[0][2*DB +: DB], 32'h1234_5678);

    // 2: read back, RO read, RO write ignored
    xact(0, 1'b1, 26'h108, '0, 32'h1234_5678, 16'h0000, 1'b0, "t2 read r2");
    xact(0, 1'b1, 26'h10C, '0, 32'h0000_CAFE, 16'h0000, 1'b0, "t2 read ro r3");
    xact(0, 1'b0, 26'h10C, 32'hFFFF_FFFF, '0, 16'h0000, 1'b0, "t2 write ro r3");
    check("t2 ctrl r3 unchanged", ctrl[0][3*DB +: DB], 32'd0);
    xact(0, 1'b1, 26'h10C, '0, 32'h0000_CAFE, 16'h0000, 1'b0, "t2 reread ro r3");
    check("t2 errc", 32'(errc[0]), 32'd0);

    // 3: decode errors
    xact(0, 1'b1, 26'h142, '0, 32'hBAD0_ADD0, 16'h0000, 1'b0, "t3 misaligned");
    xact(0, 1'b1, 26'h140, '0, 32'hBAD0_ADD0, 16'h0000, 1'b0, "t3 past end");
    check("t3 errc 2", 32'(errc[0]), 32'd2);
    xact(0, 1'b1, 26'h0FC, '0, 32'hBAD0_ADD0, 16'h0000, 1'b0, "t3 below base");
    xact(0, 1'b0, 26'h140, 32'hDEAD_BEEF, '0, 16'h0000, 1'b0, "t3 err write");
    check("t3 errc 4", 32'(errc[0]), 32'd4);
    check("t3 ctrl r2 intact", ctrl[0][2*DB +: DB], 32'h1234_5678);
    for (int i = 0; i < 300; i++)
      xact(0, 1'b1, 26'h142, '0, 32'hBAD0_ADD0, 16'h0000, 1'b0, "t3 err burst");
    check("t3 errc saturated", 32'(errc[0]), 32'd255);

    // 4: W=3 abort in the second WAIT cycle
    @(posedge clk); #1;
    sel[1] = 1'b1; rd_wr_n[1] = 1'b0; addr[1] = 26'h14; wdata[1] = 32'h5555_AAAA;
    repeat (3) @(negedge clk);
    sel[1] = 1'b0;
    seen_ack = 1'b0; seen_pl = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen_ack |= ack[1];
      seen_pl  |= |pulse[1];
    end
    check("t4 abort no ack", 32'(seen_ack), 32'd0);
    check("t4 abort no pulse", 32'(seen_pl), 32'd0);
    check("t4 abort no write", ctrl[1][5*DB +: DB], 32'd0);
    check("t4 abort no err", 32'(errc[1]), 32'd0);
    xact(1, 1'b0, 26'h14, 32'h5555_AAAA, '0, 16'h0020, 1'b0, "t4 write r5");
    check("t4 ctrl r5", ctrl[1][5*DB +: DB], 32'h5555_AAAA);
    xact(1, 1'b1, 26'h14, '0, 32'h5555_AAAA, 16'h0000, 1'b0, "t4 read r5");

    // 5: W=0 back-to-back writes with sel held
    xact(2, 1'b0, 26'h00, 32'hA000_0000, '0, 16'h0001, 1'b1, "t5 b2b r0");
    xact(2, 1'b0, 26'h04, 32'hA111_1111, '0, 16'h0002, 1'b1, "t5 b2b r1");
    xact(2, 1'b0, 26'h08, 32'hA222_2222, '0, 16'h0004, 1'b1, "t5 b2b r2");
    xact(2, 1'b0, 26'h0C, 32'hA333_3333, '0, 16'h0008, 1'b0, "t5 b2b r3");
    check("t5 ctrl r0", ctrl[2][0*DB +: DB], 32'hA000_0000);
    check("t5 ctrl r1", ctrl[2][1*DB +: DB], 32'hA111_1111);
    check("t5 ctrl r2", ctrl[2][2*DB +: DB], 32'hA222_2222);
    check("t5 ctrl r3", ctrl[2][3*DB +: DB], 32'hA333_3333);

    // 6: reset during WAIT
    @(posedge clk); #1;
    sel[1] = 1'b1; rd_wr_n[1] = 1'b0; addr[1] = 26'h04; wdata[1] = 32'h1111_1111;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6 ack low", 32'(ack[1]), 32'd0);
    check("t6 ctrl k1 cleared", 32'(|ctrl[1]), 32'd0);
    check("t6 ctrl k0 cleared", 32'(|ctrl[0]), 32'd0);
    check("t6 errc k0 cleared", 32'(errc[0]), 32'd0);
    check("t6 rdata k0 cleared", rdata[0], 32'd0);
    sel[1] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    xact(1, 1'b1, 26'h14, '0, 32'd0, 16'h0000, 1'b0, "t6 read r5");
    xact(1, 1'b1, 26'h04, '0, 32'd0, 16'h0000, 1'b0, "t6 read r1 lost");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
